// File: rtl/tts_pkg.sv
// Shared types for the strategy/host RAM arbiter: host FSM states and read-return tags.
// Latency: none (types only).
// Backpressure: none (types only).
package tts_pkg;

    // Host-side FSM. At most one host read may be in flight, so the read phases
    // have their own states. Write completion needs only the HWR state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no host read outstanding
        HWR  = 2'd1,  // write granted last cycle
        HRD1 = 2'd2,  // read issued, RAM data pending
        HRD2 = 2'd3   // capture cycle, host_rvld high
    } host_state_t;

    // Owner of the RAM read data that returns one cycle after the access.
    typedef enum logic [1:0] {
        RTAG_NONE = 2'd0,
        RTAG_SEF  = 2'd1,
        RTAG_HOST = 2'd2
    } ret_tag_t;

endpackage

// File: rtl/rcb_arb_stat.sv
// Host wait statistics: counts consecutive stalled request cycles, tracks the worst case, flags starvation.
// Latency: statistics outputs update on the clock edge after the cycle being counted.
// Backpressure: none; purely observes host_req/host_gnt. Ports: clk, reset_n, host_req, host_gnt, stat_clr, host_starved, host_wait_max.
module rcb_arb_stat #(
    parameter int WAIT_LIMIT = 16,
    parameter int WCNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  host_req,
    input  logic                  host_gnt,
    input  logic                  stat_clr,
    output logic                  host_starved,
    output logic [WCNT_WIDTH-1:0] host_wait_max
);

    localparam int unsigned LIMIT = WAIT_LIMIT;

    logic [WCNT_WIDTH-1:0] wcnt;
    logic [WCNT_WIDTH-1:0] wcnt_nxt;
    logic                  set_starved;
    logic                  new_max;

    // The counter tracks only an unbroken stall: a grant or a dropped request restarts it.
    always_comb begin
        wcnt_nxt = wcnt;
        if (host_gnt || !host_req) begin
            wcnt_nxt = '0;
        end else if (wcnt != '1) begin
            wcnt_nxt = wcnt + 1'b1;
        end
    end

    assign set_starved = (32'(wcnt_nxt) >= LIMIT);
    assign new_max     = (wcnt_nxt > host_wait_max);

    // New events take precedence over stat_clr in the same cycle, so no event is ever lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wcnt          <= '0;
            host_wait_max <= '0;
            host_starved  <= 1'b0;
        end else begin
            wcnt <= wcnt_nxt;
            if (new_max) begin
                host_wait_max <= wcnt_nxt;
            end else if (stat_clr) begin
                host_wait_max <= '0;
            end
            if (set_starved) begin
                host_starved <= 1'b1;
            end else if (stat_clr) begin
                host_starved <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rcb_host_arb.sv
// Single-port RAM arbiter: strategy reads have absolute priority, the host gets the remaining cycles.
// Latency: RAM driven in the request cycle; sef_rvld/host_rvld 2 cycles after the access.
// Backpressure: host is stalled via host_gnt (request held until granted); strategy never stalls.
// Ports: strategy read (sef_*), host access (host_*), RAM port (ram_*), statistics (stat_clr, host_starved, host_wait_max).
module rcb_host_arb import tts_pkg::*; #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 64,
    parameter int WAIT_LIMIT = 16,
    parameter int WCNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sef_rd,
    input  logic [ADDR_WIDTH-1:0] sef_addr,
    output logic [DATA_WIDTH-1:0] sef_rdata,
    output logic                  sef_rvld,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvld,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  stat_clr,
    output logic                  host_starved,
    output logic [WCNT_WIDTH-1:0] host_wait_max
);

    host_state_t state;
    ret_tag_t    tag_q;
    logic        sef_go;
    logic        host_ok;

    // Requests seen while reset_n is low must not reach the RAM.
    assign sef_go   = reset_n & sef_rd;
    assign host_ok  = (state == IDLE) || (state == HWR);
    assign host_gnt = reset_n & host_req & ~sef_rd & host_ok;

    assign ram_en    = sef_go | host_gnt;
    assign ram_we    = host_gnt & host_we;
    assign ram_addr  = sef_go ? sef_addr : host_addr;
    assign ram_wdata = host_wdata;

    // The tag registered with each read steers the returning RAM word to exactly one
    // consumer; clearing it on reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            tag_q      <= RTAG_NONE;
            sef_rvld   <= 1'b0;
            host_rvld  <= 1'b0;
            sef_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            if (sef_go) begin
                tag_q <= RTAG_SEF;
            end else if (host_gnt && !host_we) begin
                tag_q <= RTAG_HOST;
            end else begin
                tag_q <= RTAG_NONE;
            end

            sef_rvld <= (tag_q == RTAG_SEF);
            if (tag_q == RTAG_SEF) begin
                sef_rdata <= ram_rdata;
            end

            // host_rvld is high exactly while the FSM sits in HRD2.
            host_rvld <= (state == HRD1);
            if (tag_q == RTAG_HOST) begin
                host_rdata <= ram_rdata;
            end

            if (host_gnt) begin
                state <= host_we ? HWR : HRD1;
            end else begin
                case (state)
                    HRD1:    state <= HRD2;
                    HRD2:    state <= IDLE;
                    HWR:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    rcb_arb_stat #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .WCNT_WIDTH (WCNT_WIDTH)
    ) u_stat (
        .clk           (clk),
        .reset_n       (reset_n),
        .host_req      (host_req),
        .host_gnt      (host_gnt),
        .stat_clr      (stat_clr),
        .host_starved  (host_starved),
        .host_wait_max (host_wait_max)
    );

endmodule

// File: tb/tb_rcb_host_arb.sv
module tb_rcb_host_arb;

    logic        clk;
    logic        reset_n;
    logic        sef_rd;
    logic [13:0] sef_addr;
    logic [63:0] sef_rdata;
    logic        sef_rvld;
    logic        host_req;
    logic        host_we;
    logic [13:0] host_addr;
    logic [63:0] host_wdata;
    logic        host_gnt;
    logic [63:0] host_rdata;
    logic        host_rvld;
    logic        ram_en;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;
    logic        stat_clr;
    logic        host_starved;
    logic [7:0]  host_wait_max;

    rcb_host_arb dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sef_rd        (sef_rd),
        .sef_addr      (sef_addr),
        .sef_rdata     (sef_rdata),
        .sef_rvld      (sef_rvld),
        .host_req      (host_req),
        .host_we       (host_we),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_gnt      (host_gnt),
        .host_rdata    (host_rdata),
        .host_rvld     (host_rvld),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .stat_clr      (stat_clr),
        .host_starved  (host_starved),
        .host_wait_max (host_wait_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM seen by the DUT.
    logic [63:0] mem [0:16383];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Reference model state
    logic [63:0] shadow [0:16383];   // what the memory must contain
    bit          exp_sv [int];       // cycle -> strategy data due
    logic [63:0] exp_sd [int];
    bit          exp_hv [int];       // cycle -> host data due
    logic [63:0] exp_hd [int];
    logic [63:0] sef_hold, host_hold;
    int          last_rd;            // cycle of the last host read grant
    int          m_wcnt, m_wmax;
    bit          m_starved;
    int          cyc;
    int          checks, errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick(input bit s_rd, input logic [13:0] s_a,
                        input bit h_req, input bit h_we, input logic [13:0] h_a,
                        input logic [63:0] h_wd, input bit clr, input bit rst,
                        output bit g);
        bit e_sv, e_hv, e_g;
        @(negedge clk);
        // Registered outputs for this cycle
        e_sv = exp_sv.exists(cyc);
        if (e_sv) sef_hold = exp_sd[cyc];
        e_hv = exp_hv.exists(cyc);
        if (e_hv) host_hold = exp_hd[cyc];
        chk("sef_rvld", sef_rvld, e_sv);
        chk("sef_rdata", sef_rdata, sef_hold);
        chk("host_rvld", host_rvld, e_hv);
        chk("host_rdata", host_rdata, host_hold);
        chk("host_wait_max", host_wait_max, m_wmax);
        chk("host_starved", host_starved, m_starved);
        // Drive inputs
        reset_n    = !rst;
        sef_rd     = s_rd;
        sef_addr   = s_a;
        host_req   = h_req;
        host_we    = h_we;
        host_addr  = h_a;
        host_wdata = h_wd;
        stat_clr   = clr;
        #1;
        e_g = !rst && h_req && !s_rd && (cyc > last_rd + 2);
        chk("host_gnt", host_gnt, e_g);
        chk("ram_en", ram_en, !rst && (s_rd || e_g));
        chk("ram_we", ram_we, e_g && h_we);
        if (!rst && s_rd)  chk("ram_addr_sef", ram_addr, s_a);
        else if (e_g)      chk("ram_addr_host", ram_addr, h_a);
        if (e_g && h_we)   chk("ram_wdata", ram_wdata, h_wd);
        // Model update
        if (rst) begin
            exp_sv.delete(cyc + 1); exp_sv.delete(cyc + 2);
            exp_hv.delete(cyc + 1); exp_hv.delete(cyc + 2);
            sef_hold = '0; host_hold = '0;
            last_rd = -100;
            m_wcnt = 0; m_wmax = 0; m_starved = 1'b0;
        end else begin
            if (s_rd) begin
                exp_sv[cyc + 2] = 1'b1;
                exp_sd[cyc + 2] = shadow[s_a];
            end
            if (e_g && h_we) shadow[h_a] = h_wd;
            if (e_g && !h_we) begin
                exp_hv[cyc + 2] = 1'b1;
                exp_hd[cyc + 2] = shadow[h_a];
                last_rd = cyc;
            end
            if (e_g || !h_req) m_wcnt = 0;
            else if (m_wcnt < 255) m_wcnt = m_wcnt + 1;
            if (m_wcnt > m_wmax) m_wmax = m_wcnt;
            else if (clr) m_wmax = 0;
            if (m_wcnt >= 16) m_starved = 1'b1;
            else if (clr) m_starved = 1'b0;
        end
        g = e_g;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit g;
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0, g);
    endtask

    initial begin
        bit          g;
        bit          hr, hw;
        logic [13:0] ha;
        logic [63:0] hd;
        logic [63:0] wd [1:3];

        checks = 0; errors = 0; cyc = 0;
        sef_hold = '0; host_hold = '0; last_rd = -100;
        m_wcnt = 0; m_wmax = 0; m_starved = 1'b0;
        for (int i = 0; i < 16384; i++) begin
            mem[i]    = {$urandom, $urandom};
            shadow[i] = mem[i];
        end
        mem[5] = 64'hA5; shadow[5] = 64'hA5;

        reset_n = 1'b0; sef_rd = 0; sef_addr = 0; host_req = 0; host_we = 0;
        host_addr = 0; host_wdata = 0; stat_clr = 0;
        repeat (2) @(posedge clk);

        // Reset state, with requests presented during reset ignored
        tick(1, 14'h5, 1, 0, 14'h7, 0, 0, 1, g);
        tick(1, 14'h5, 1, 1, 14'h7, 64'h1234, 0, 1, g);
        tick(0, 0, 0, 0, 0, 0, 0, 1, g);
        idle(3);

        // Strategy read of a known word
        tick(1, 14'h5, 0, 0, 0, 0, 0, 0, g);
        idle(3);
        chk("sef_a5", sef_rdata, 64'hA5);

        // Host read held off by five strategy reads
        for (int i = 0; i < 5; i++) tick(1, 14'(i), 1, 0, 14'h10, 0, 0, 0, g);
        tick(0, 0, 1, 0, 14'h10, 0, 0, 0, g);
        chk("gnt_after_sef", g, 1'b1);
        idle(3);
        chk("wait_max_5", host_wait_max, 8'd5);
        chk("starved_0", host_starved, 1'b0);

        // Back-to-back host writes, then read one back via the strategy port
        for (int i = 1; i <= 3; i++) begin
            wd[i] = {$urandom, $urandom};
            tick(0, 0, 1, 1, 14'(i), wd[i], 0, 0, g);
            chk("wr_b2b_gnt", g, 1'b1);
        end
        tick(1, 14'h2, 0, 0, 0, 0, 0, 0, g);
        idle(3);
        chk("sef_after_wr", sef_rdata, wd[2]);

        // Host read followed immediately by a strategy read
        tick(0, 0, 1, 0, 14'h3, 0, 0, 0, g);
        tick(1, 14'h5, 0, 0, 0, 0, 0, 0, g);
        idle(3);
        chk("interleave_host", host_rdata, wd[3]);
        chk("interleave_sef", sef_rdata, 64'hA5);

        // Starvation under 20 cycles of strategy reads, then clear
        for (int i = 0; i < 20; i++) tick(1, 14'(i), 1, 1, 14'h20, 64'hBEEF, 0, 0, g);
        tick(0, 0, 1, 1, 14'h20, 64'hBEEF, 0, 0, g);
        idle(1);
        chk("starved_set", host_starved, 1'b1);
        chk("wait_max_20", host_wait_max, 8'd20);
        tick(0, 0, 0, 0, 0, 0, 1, 0, g);
        idle(2);
        chk("starved_clr", host_starved, 1'b0);
        chk("wait_max_clr", host_wait_max, 8'd0);

        // Reset the cycle after a host read grant drops the read
        tick(0, 0, 1, 0, 14'h2, 0, 0, 0, g);
        tick(0, 0, 0, 0, 0, 0, 0, 1, g);
        idle(4);
        chk("rst_host_rdata", host_rdata, 64'd0);
        tick(0, 0, 1, 0, 14'h2, 0, 0, 0, g);
        chk("post_rst_gnt", g, 1'b1);
        idle(3);
        chk("post_rst_read", host_rdata, wd[2]);

        // Randomized traffic; the host holds each request until granted
        hr = 0; hw = 0; ha = 0; hd = 0;
        for (int i = 0; i < 600; i++) begin
            if (!hr && $urandom_range(1, 0) == 1) begin
                hr = 1;
                hw = ($urandom_range(1, 0) == 1);
                ha = 14'($urandom_range(15, 0));
                hd = {$urandom, $urandom};
            end
            tick($urandom_range(2, 0) == 0, 14'($urandom_range(15, 0)), hr, hw, ha, hd,
                 $urandom_range(40, 0) == 0, $urandom_range(80, 0) == 0, g);
            if (g) hr = 0;
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rcb_host_arb.md
RCB_HOST_ARB -- requirements
Module: rcb_host_arb

Interface
REQ-001 Parameters SHALL be as follows:
- ADDR_WIDTH, default 14, RAM word address width.
- DATA_WIDTH, default 64, RAM word width.
- WAIT_LIMIT, default 16, host-wait cycles that set the starvation flag.
- WCNT_WIDTH, default 8, width of the wait counters.

REQ-002 Ports SHALL be, in order (name, direction, width, meaning):
- clk  in  1  core clock.
- reset_n  in  1  reset, synchronous, active-low.
- sef_rd  in  1  strategy read request, single-cycle pulse.
- sef_addr  in  ADDR_WIDTH  strategy read address.
- sef_rdata  out  DATA_WIDTH  strategy read data.
- sef_rvld  out  1  sef_rdata valid.
- host_req  in  1  host access request, held until granted.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_WIDTH  host address.
- host_wdata  in  DATA_WIDTH  host write data.
- host_gnt  out  1  host request accepted this cycle.
- host_rdata  out  DATA_WIDTH  host read data.
- host_rvld  out  1  host_rdata valid.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after ram_en with ram_we = 0.
- stat_clr  in  1  clears the statistics outputs.
- host_starved  out  1  sticky starvation flag.
- host_wait_max  out  WCNT_WIDTH  worst observed host wait, in cycles.

Function
REQ-003 The RAM port SHALL be driven combinationally in the same cycle as the winning request, with one access per cycle.
REQ-004 sef_rd SHALL have absolute priority: ram_en=1, ram_we=0, ram_addr=sef_addr, host_gnt=0.
REQ-005 sef_rvld SHALL assert exactly 2 cycles after sef_rd, with sef_rdata registered from ram_rdata, independent of host traffic (fixed strategy latency).
REQ-006 host_gnt SHALL assert when all of the following hold:
- host_req=1
- sef_rd=0
- state is IDLE, or state is HWR.
REQ-007 On a granted host write, the RAM port SHALL carry ram_we=1 with host_addr and host_wdata.
REQ-008 On a granted host read, ram_we SHALL be 0.
REQ-009 The host FSM states SHALL be:
- IDLE: no host read outstanding.
- HWR: write granted last cycle.
- HRD1: read issued, RAM data pending.
- HRD2: capture cycle.
REQ-010 The host FSM transitions SHALL be:
- Granted write goes to HWR.
- Granted read goes to HRD1.
- HRD1 goes to HRD2.
- HRD2 goes to IDLE.
- HWR with no grant goes to IDLE.
REQ-011 Back-to-back host writes SHALL be permitted, one per cycle.
REQ-012 The host SHALL have at most one read outstanding, so host_gnt=0 in HRD1 and HRD2.
REQ-013 host_rvld SHALL pulse for one cycle in the cycle the FSM is in HRD2, i.e. 2 cycles after the read grant.
REQ-014 host_rdata SHALL hold its value until the next host read returns.
REQ-015 A read-data return tag SHALL steer each ram_rdata to exactly one of sef_rdata or host_rdata; no data SHALL be lost or duplicated when the strategy and host pipelines interleave.
REQ-016 The wait counter SHALL behave as follows:
- It counts consecutive cycles with host_req=1 and host_gnt=0.
- It saturates at 2^WCNT_WIDTH-1.
- It clears on grant.
REQ-017 host_wait_max SHALL update to the wait counter value whenever the counter exceeds the current host_wait_max.
REQ-018 host_starved SHALL set when the wait counter reaches WAIT_LIMIT and SHALL remain set until stat_clr.
REQ-019 stat_clr SHALL zero host_starved and host_wait_max next cycle; a set event in the same cycle SHALL win over the clear.
REQ-020 Host write followed by strategy read of the same address SHALL return the new data, because the write commits before the later RAM cycle.

Reset
REQ-021 Synchronous reset SHALL force:
- FSM to IDLE.
- sef_rvld, host_rvld, host_gnt, ram_en, ram_we = 0.
- sef_rdata, host_rdata = 0.
- Wait counter, host_wait_max, host_starved = 0.
REQ-022 Reads in flight at reset SHALL be dropped, with no rvld after reset.
REQ-023 Requests presented during reset SHALL be ignored.

Structure
REQ-024 The host FSM state enum and the return-tag encoding SHALL reside in the shared tts_pkg.
REQ-025 The wait/statistics logic SHALL be a sub-module rcb_arb_stat; the arbitration and return pipeline SHALL remain in rcb_host_arb.

Verification
REQ-026 sef_rd at cycle 10, addr 0x0005, RAM word 0xA5 -> sef_rvld at cycle 12 with sef_rdata 0xA5; no host_rvld.
REQ-027 host_req read addr 0x0010 held while sef_rd asserted at cycles 20-24 -> grant at cycle 25, host_rvld at 27, host_wait_max = 5, host_starved = 0.
REQ-028 Three consecutive host writes to 0x1..0x3 -> host_gnt on three consecutive cycles; subsequent sef_rd of 0x2 returns the written data.
REQ-029 host_req held under 20 cycles of continuous sef_rd, WAIT_LIMIT 16 -> host_starved set at wait count 16; stat_clr afterwards -> both statistics outputs return to 0.
REQ-030 Host read granted at cycle 30, sef_rd at 31 -> host_rvld at 32, sef_rvld at 33, correct data on each.
REQ-031 reset_n low in the cycle after a host read grant -> no host_rvld; all outputs 0; a new read after reset completes normally.
